// File: rtl/ldpc_enc_sequencer.sv
// Frame sequencer for the QC LDPC encoder: walks the info-word source addresses,
// aligns encoder valid to the source read data and emits one codeword-valid per frame.
// Define LDPC_SEQ_CONT_EN for continuous mode (start port ignored, frames run back-to-back).
`timescale 1ns/1ps
module ldpc_enc_sequencer #(
    parameter int INFO_BLOCKS = 18,
    parameter int ADDR_W      = 5,
    parameter int ENC_LATENCY = 2,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              fifo_full,
    output logic [ADDR_W-1:0] src_addr,
    output logic              enc_valid,
    output logic              cw_valid,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_cnt
);

    // One phase counter is shared by WAIT and GAP; it must reach the larger of the two.
    localparam int PH_MAX = (ENC_LATENCY > GAP_CYCLES) ? ENC_LATENCY : GAP_CYCLES;
    localparam int PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(INFO_BLOCKS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        WAIT = 3'd2,
        EMIT = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t          state_reg;
    logic [PH_W-1:0] ph_cnt_reg;
    logic            start_eff;

`ifdef LDPC_SEQ_CONT_EN
    logic unused_start;
    assign unused_start = start;
    assign start_eff    = 1'b1;
`else
    assign start_eff    = start;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            ph_cnt_reg <= '0;
            src_addr   <= '0;
            enc_valid  <= 1'b0;
            cw_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            // Source RAM has one cycle of read latency, so valid trails the address phase.
            enc_valid  <= (state_reg == LOAD);
            cw_valid   <= 1'b0;
            frame_done <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (start_eff && !fifo_full) begin
                        state_reg <= LOAD;
                        src_addr  <= '0;
                        busy      <= 1'b1;
                    end
                end

                LOAD: begin
                    if (src_addr == LAST_ADDR) begin
                        state_reg  <= WAIT;
                        src_addr   <= '0;
                        ph_cnt_reg <= '0;
                    end else begin
                        src_addr <= src_addr + ADDR_W'(1);
                    end
                end

                WAIT: begin
                    if (int'(ph_cnt_reg) >= ENC_LATENCY) begin
                        state_reg <= EMIT;
                    end else begin
                        ph_cnt_reg <= ph_cnt_reg + PH_W'(1);
                    end
                end

                EMIT: begin
                    // The encoder holds its codeword while the FIFO is full; retry every cycle.
                    if (!fifo_full) begin
                        cw_valid   <= 1'b1;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + CNT_W'(1);
                        ph_cnt_reg <= '0;
                        if (GAP_CYCLES == 0) begin
                            state_reg <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            state_reg <= GAP;
                        end
                    end
                end

                GAP: begin
                    if (int'(ph_cnt_reg) >= GAP_CYCLES - 1) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        ph_cnt_reg <= ph_cnt_reg + PH_W'(1);
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    src_addr  <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
